// File: rtl/ram_access_scheduler_if.sv
// Bundle between the cartridge requesters and the shared RAM port scheduler.
// The master side drives requests and RAM read data; the slave side is the scheduler.
interface ram_access_scheduler_if #(
  parameter int COUNT  = 5,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
);
  logic [COUNT-1:0]        req;
  logic [COUNT-1:0]        we;
  logic [COUNT*ADDR_W-1:0] addr;
  logic [COUNT*DATA_W-1:0] din;
  logic [COUNT-1:0]        ack;
  logic [DATA_W-1:0]       dout;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;
  logic                    ram_oe_n;
  logic                    ram_we_n;
  logic                    ram_rfsh_n;
  logic                    busy;

  modport master (
    output req, we, addr, din, ram_dout,
    input  ack, dout, ram_addr, ram_din, ram_oe_n, ram_we_n, ram_rfsh_n, busy
  );

  modport slave (
    input  req, we, addr, din, ram_dout,
    output ack, dout, ram_addr, ram_din, ram_oe_n, ram_we_n, ram_rfsh_n, busy
  );
endinterface

// File: rtl/ram_access_scheduler.sv
// Shares one external RAM port among COUNT requesters with periodic refresh.
// Define RAM_SCHED_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module ram_access_scheduler #(
  parameter int COUNT            = 5,
  parameter int ADDR_W           = 22,
  parameter int DATA_W           = 8,
  parameter int ACCESS_CYCLES    = 4,
  parameter int REFRESH_INTERVAL = 390,
  parameter int REFRESH_CYCLES   = 6
) (
  input  logic clk,
  input  logic rst_n,
  ram_access_scheduler_if.slave bus
);
  localparam int IDX_W   = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int PHASE_W = $clog2(((ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES : REFRESH_CYCLES) + 1);
  localparam int RFSH_W  = $clog2(REFRESH_INTERVAL);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, REFRESH} state_t;

  state_t              state_reg, state_next;
  logic [PHASE_W-1:0]  phase_reg, phase_next;
  logic [RFSH_W-1:0]   rfsh_cnt_reg;
  logic                pending_reg;
  logic [IDX_W-1:0]    grant_reg;
  logic                op_we_reg;
  logic [ADDR_W-1:0]   ram_addr_reg;
  logic [DATA_W-1:0]   ram_din_reg;
  logic [DATA_W-1:0]   dout_reg;
`ifndef RAM_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0]    rr_ptr_reg;
`endif

  logic [ADDR_W-1:0]   addr_arr [COUNT];
  logic [DATA_W-1:0]   din_arr  [COUNT];
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand;
  logic                any_req;
  logic                grant_now;
  logic                rfsh_wrap;
  logic                oe_n, we_n, rfsh_n;
  logic [COUNT-1:0]    ack;

  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_slice
      assign addr_arr[gi] = bus.addr[gi*ADDR_W +: ADDR_W];
      assign din_arr[gi]  = bus.din[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the highest search offset down so the lowest offset with REQ set wins.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = |bus.req;
    for (int k = COUNT - 1; k >= 0; k--) begin
`ifdef RAM_SCHED_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((int'(rr_ptr_reg) + k) % COUNT);
`endif
      if (bus.req[cand]) winner = cand;
    end
  end

  assign rfsh_wrap = (rfsh_cnt_reg == RFSH_W'(REFRESH_INTERVAL - 1));

  always_comb begin
    state_next = state_reg;
    phase_next = '0;
    grant_now  = 1'b0;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    rfsh_n     = 1'b1;
    ack        = '0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = REFRESH;
        end else if (any_req) begin
          grant_now  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        oe_n = op_we_reg;
        we_n = ~op_we_reg;
        if (phase_reg == PHASE_W'(ACCESS_CYCLES - 1)) state_next = DONE;
        else phase_next = phase_reg + 1'b1;
      end
      DONE: begin
        ack        = COUNT'(1) << grant_reg;
        state_next = IDLE;
      end
      REFRESH: begin
        rfsh_n = 1'b0;
        if (phase_reg == PHASE_W'(REFRESH_CYCLES - 1)) state_next = IDLE;
        else phase_next = phase_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      rfsh_cnt_reg <= '0;
      pending_reg  <= 1'b0;
      grant_reg    <= '0;
      op_we_reg    <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      dout_reg     <= '0;
`ifndef RAM_SCHED_FIXED_PRIO_EN
      rr_ptr_reg   <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      rfsh_cnt_reg <= rfsh_wrap ? '0 : rfsh_cnt_reg + 1'b1;
      // Entering REFRESH consumes the flag; a wrap while already pending is simply absorbed.
      if (state_reg == IDLE && pending_reg) pending_reg <= 1'b0;
      else if (rfsh_wrap)                   pending_reg <= 1'b1;
      if (grant_now) begin
        grant_reg    <= winner;
        op_we_reg    <= bus.we[winner];
        ram_addr_reg <= addr_arr[winner];
        ram_din_reg  <= din_arr[winner];
      end
      if (state_reg == ACCESS && phase_reg == PHASE_W'(ACCESS_CYCLES - 1) && !op_we_reg)
        dout_reg <= bus.ram_dout;
`ifndef RAM_SCHED_FIXED_PRIO_EN
      if (state_reg == DONE)
        rr_ptr_reg <= (grant_reg == IDX_W'(COUNT - 1)) ? '0 : grant_reg + 1'b1;
`endif
    end
  end

  assign bus.ack        = ack;
  assign bus.dout       = dout_reg;
  assign bus.ram_addr   = ram_addr_reg;
  assign bus.ram_din    = ram_din_reg;
  assign bus.ram_oe_n   = oe_n;
  assign bus.ram_we_n   = we_n;
  assign bus.ram_rfsh_n = rfsh_n;
  assign bus.busy       = (state_reg != IDLE);
endmodule
